// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Purpose : shared constants for the 32-point FFT frame sequencer.
//           - stage codes driven to the redistribution network
//           - FSM state encoding used by fft_stage_ctrl
//           - default vector-unit count
// Ports   : none (package)
// -----------------------------------------------------------------------------
package fft_pkg;

  // fft_size codes understood by the redistribution network, in issue order.
  localparam logic [5:0] STAGE_32 = 6'b100000;
  localparam logic [5:0] STAGE_8  = 6'b001000;
  localparam logic [5:0] STAGE_2  = 6'b000010;

  localparam int NUM_VU_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_ISSUE = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_stage_ctrl_if
// Purpose : bundles the frame handshakes, redistribution-network controls and
//           vector-unit start/done lines of the FFT frame sequencer.
// Signals : in_valid/in_ready     upstream frame handshake
//           out_valid/out_ready   downstream frame handshake
//           stage_code[5:0]       fft_size code to the redistribution network
//           redist_start          network input-register strobe
//           vec_start             start pulse to all vector units
//           vec_done[NUM_VU-1:0]  per-unit done pulses
//           twiddle_sel[1:0]      twiddle ROM bank (stage index)
//           busy, err_timeout     status
// Modports: master = the sequencer, slave = its environment.
// -----------------------------------------------------------------------------
interface fft_stage_ctrl_if #(
  parameter int NUM_VU = fft_pkg::NUM_VU_DEF
);
  import fft_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        stage_code;
  logic              redist_start;
  logic              vec_start;
  logic [NUM_VU-1:0] vec_done;
  logic [1:0]        twiddle_sel;
  logic              busy;
  logic              err_timeout;

  modport master (
    input  in_valid, out_ready, vec_done,
    output in_ready, out_valid, stage_code, redist_start, vec_start,
           twiddle_sel, busy, err_timeout
  );

  modport slave (
    output in_valid, out_ready, vec_done,
    input  in_ready, out_valid, stage_code, redist_start, vec_start,
           twiddle_sel, busy, err_timeout
  );

endinterface

// File: rtl/fft_stage_ctrl_timer.sv
// -----------------------------------------------------------------------------
// stage_timer
// Purpose : per-stage watchdog for the FFT sequencer. Cleared by load_i,
//           counts while en_i, flags expire_o on the last allowed cycle.
// Ports   : clk       clock
//           rst       asynchronous active-low reset
//           load_i    clear the count to 0
//           en_i      increment the count (saturating)
//           expire_o  count == TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module stage_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i && count_q != 8'hFF) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count 0 is the first WAIT cycle, so TIMEOUT_CYC-1 marks the last one.
  assign expire_o = (count_q == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fft_stage_ctrl
// Purpose : frame-level sequencer for the 32-point FFT datapath. Per accepted
//           frame it steps the redistribution network through stage codes
//           32 -> 8 -> 2, starts the vector units once per stage, collects all
//           done pulses, then offers the frame downstream. A stage that does
//           not complete within TIMEOUT_CYC WAIT cycles aborts the frame and
//           raises the sticky err_timeout.
// Ports   : clk           clock
//           rst           asynchronous active-low reset
//           bus           fft_stage_ctrl_if.master (handshakes, stage/vector
//                         controls, status)
//           frame_cycles  [15:0] in-handshake to out_valid of last frame
//                         (FFT_CTRL_PERF_EN only)
//           frame_count   [15:0] completed frames (FFT_CTRL_PERF_EN only)
// Build   : define FFT_CTRL_PERF_EN to add the saturating performance counters.
// -----------------------------------------------------------------------------
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int NUM_VU      = NUM_VU_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  fft_stage_ctrl_if.master        bus
`ifdef FFT_CTRL_PERF_EN
  ,
  output logic [15:0]             frame_cycles,
  output logic [15:0]             frame_count
`endif
);

  state_t            state_q,      state_d;
  logic [5:0]        stage_q,      stage_d;
  logic [1:0]        twiddle_q,    twiddle_d;
  logic [NUM_VU-1:0] done_mask_q,  done_mask_d;
  logic              redist_q,     redist_d;
  logic              vec_start_q,  vec_start_d;
  logic              out_valid_q,  out_valid_d;
  logic              err_q,        err_d;

  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_expire;
  logic [NUM_VU-1:0] mask_merged;

  stage_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  // Include this cycle's pulses so a stage completes on the edge that sees
  // the last done, not one cycle later.
  assign mask_merged = done_mask_q | bus.vec_done;

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    twiddle_d   = twiddle_q;
    done_mask_d = done_mask_q;
    redist_d    = 1'b0;
    vec_start_d = 1'b0;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d   = ST_LOAD;
          stage_d   = STAGE_32;
          twiddle_d = 2'd0;
          redist_d  = 1'b1;
          err_d     = 1'b0;
        end
      end

      ST_LOAD: begin
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        vec_start_d = 1'b1;
        done_mask_d = '0;
        tmr_load    = 1'b1;
        state_d     = ST_WAIT;
      end

      ST_WAIT: begin
        done_mask_d = mask_merged;
        tmr_en      = 1'b1;
        // Completion is tested first so it wins over an expiring timer.
        if (&mask_merged) begin
          if (stage_q != STAGE_2) begin
            stage_d   = stage_q >> 2;
            twiddle_d = twiddle_q + 2'd1;
            redist_d  = 1'b1;
            state_d   = ST_LOAD;
          end else begin
            out_valid_d = 1'b1;
            state_d     = ST_DRAIN;
          end
        end else if (tmr_expire) begin
          err_d   = 1'b1;
          stage_d = '0;
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          stage_d     = '0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      twiddle_q   <= '0;
      done_mask_q <= '0;
      redist_q    <= 1'b0;
      vec_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      twiddle_q   <= twiddle_d;
      done_mask_q <= done_mask_d;
      redist_q    <= redist_d;
      vec_start_q <= vec_start_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready     = (state_q == ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.stage_code   = stage_q;
  assign bus.redist_start = redist_q;
  assign bus.vec_start    = vec_start_q;
  assign bus.twiddle_sel  = twiddle_q;
  assign bus.err_timeout  = err_q;

`ifdef FFT_CTRL_PERF_EN
  logic [15:0] run_cnt_q;
  logic [15:0] frame_cycles_q;
  logic [15:0] frame_count_q;

  // run_cnt_q is 1 in the first LOAD cycle, i.e. it counts cycles elapsed
  // since the accepting cycle; the +1 at capture covers the edge into DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q      <= '0;
      frame_cycles_q <= '0;
      frame_count_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.in_valid) begin
        run_cnt_q <= 16'd1;
      end else if (state_q != ST_IDLE && state_q != ST_DRAIN &&
                   run_cnt_q != 16'hFFFF) begin
        run_cnt_q <= run_cnt_q + 16'd1;
      end

      if (state_q == ST_WAIT && state_d == ST_DRAIN) begin
        frame_cycles_q <= (run_cnt_q == 16'hFFFF) ? 16'hFFFF : run_cnt_q + 16'd1;
      end

      if (state_q == ST_DRAIN && bus.out_ready && frame_count_q != 16'hFFFF) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign frame_cycles = frame_cycles_q;
  assign frame_count  = frame_count_q;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_stage_ctrl
// Directed and randomized frames against a frame-level reference model:
// for each frame the expected stage codes, twiddle banks, pulse timing,
// latency (1 + sum over stages of 2 + slowest unit offset), timeout outcome
// and drain behaviour are derived from the unit done offsets alone.
// A done offset k means the unit pulses done in the k-th WAIT cycle, the
// cycle in which vec_start is high being WAIT cycle 1.
// -----------------------------------------------------------------------------
module tb_fft_stage_ctrl;
  import fft_pkg::*;

  localparam int NUM_VU      = 8;
  localparam int TIMEOUT_CYC = 64;

  logic clk;
  logic rst;

  fft_stage_ctrl_if #(.NUM_VU(NUM_VU)) bus ();

`ifdef FFT_CTRL_PERF_EN
  logic [15:0] frame_cycles;
  logic [15:0] frame_count;
`endif

  fft_stage_ctrl #(
    .NUM_VU      (NUM_VU),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus)
`ifdef FFT_CTRL_PERF_EN
    ,
    .frame_cycles (frame_cycles),
    .frame_count  (frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frame_no = 0;
  int off [NUM_VU];
  int hang     = -1;
  int err_model = 0;
  logic [5:0] code_tbl [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_code"},    32'(bus.stage_code),   0);
    chk({tag, "_tw"},      32'(bus.twiddle_sel),  0);
    chk({tag, "_redist"},  32'(bus.redist_start), 0);
    chk({tag, "_vs"},      32'(bus.vec_start),    0);
    chk({tag, "_ov"},      32'(bus.out_valid),    0);
    chk({tag, "_busy"},    32'(bus.busy),         0);
    chk({tag, "_err"},     32'(bus.err_timeout),  0);
    chk({tag, "_inready"}, 32'(bus.in_ready),     1);
  endtask

  task automatic set_offsets(input int base, input int u0, input int u7);
    for (int i = 0; i < NUM_VU; i++) off[i] = base;
    off[0] = u0;
    off[7] = u7;
  endtask

  // Runs one frame from an IDLE cycle; returns observing the next IDLE cycle.
  task automatic run_frame(input int hold, input bit junk, input int rst_stage, input int rst_w);
    int hs;
    int maxoff;
    int exp_lat;
    int last;
    logic [NUM_VU-1:0] d;

    maxoff = 0;
    for (int i = 0; i < NUM_VU; i++)
      if (i != hang && off[i] > maxoff) maxoff = off[i];
    exp_lat = 1 + 3 * (2 + maxoff);
    last    = (hang >= 0) ? TIMEOUT_CYC : maxoff;
    frame_no++;

    chk("idle_in_ready", 32'(bus.in_ready), 1);
    chk("idle_busy",     32'(bus.busy),     0);
    chk("idle_err",      32'(bus.err_timeout), err_model);

    bus.in_valid = 1'b1;
    hs = cyc;
    tick();
    err_model = 0;

    for (int s = 0; s < 3; s++) begin
      chk("load_redist", 32'(bus.redist_start), 1);
      chk("load_code",   32'(bus.stage_code),   32'(code_tbl[s]));
      chk("load_tw",     32'(bus.twiddle_sel),  s);
      chk("load_err",    32'(bus.err_timeout),  0);
      chk("load_busy",   32'(bus.busy),         1);
      bus.in_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.vec_done = junk ? NUM_VU'($urandom) : '0;
      tick();
      chk("issue_vs",     32'(bus.vec_start),    0);
      chk("issue_redist", 32'(bus.redist_start), 0);
      bus.vec_done = junk ? NUM_VU'($urandom) : '0;
      tick();

      for (int w = 1; w <= last; w++) begin
        chk("wait_vs",      32'(bus.vec_start),    (w == 1) ? 1 : 0);
        chk("wait_redist",  32'(bus.redist_start), 0);
        chk("wait_inready", 32'(bus.in_ready),     0);
        chk("wait_err",     32'(bus.err_timeout),  0);
        chk("wait_code",    32'(bus.stage_code),   32'(code_tbl[s]));
        if (s == rst_stage && w == rst_w) begin
          bus.vec_done = '0;
          bus.in_valid = 1'b0;
          rst = 1'b0;
          #1;
          chk_reset_state("midrst");
          tick();
          chk_reset_state("midrst_hold");
          rst = 1'b1;
          err_model = 0;
          $display("frame %0d: reset in stage %0d wait cycle %0d", frame_no, s, w);
          return;
        end
        d = '0;
        for (int i = 0; i < NUM_VU; i++)
          if (i != hang && (w == off[i] || (junk && w > off[i] && $urandom_range(0, 3) == 0)))
            d[i] = 1'b1;
        bus.vec_done = d;
        tick();
        bus.vec_done = '0;
      end

      if (hang >= 0) begin
        chk("tmo_err",     32'(bus.err_timeout), 1);
        chk("tmo_inready", 32'(bus.in_ready),    1);
        chk("tmo_busy",    32'(bus.busy),        0);
        chk("tmo_code",    32'(bus.stage_code),  0);
        chk("tmo_ov",      32'(bus.out_valid),   0);
        bus.in_valid = 1'b0;
        err_model = 1;
        $display("frame %0d: unit %0d hung, timeout in stage 0", frame_no, hang);
        return;
      end
    end

    chk("drain_latency", cyc - hs, exp_lat);
    chk("drain_ov",      32'(bus.out_valid),    1);
    chk("drain_inready", 32'(bus.in_ready),     0);
    chk("drain_redist",  32'(bus.redist_start), 0);
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.vec_done = junk ? NUM_VU'($urandom) : '0;
      tick();
      chk("hold_ov",      32'(bus.out_valid), 1);
      chk("hold_inready", 32'(bus.in_ready),  0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.vec_done  = '0;
    chk("done_ov",      32'(bus.out_valid),  0);
    chk("done_inready", 32'(bus.in_ready),   1);
    chk("done_code",    32'(bus.stage_code), 0);
    chk("done_busy",    32'(bus.busy),       0);
    $display("frame %0d: max_off=%0d hold=%0d latency=%0d expected=%0d",
             frame_no, maxoff, hold, cyc - hs, exp_lat);
  endtask

  initial begin
    code_tbl[0] = STAGE_32;
    code_tbl[1] = STAGE_8;
    code_tbl[2] = STAGE_2;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.vec_done = '0;
    tick();
    tick();
    chk_reset_state("reset");
    rst = 1'b1;
    tick();

    // 1: all units done in WAIT cycle 3 -> 16-cycle latency; run twice.
    set_offsets(3, 3, 3);
    hang = -1;
    run_frame(0, 1'b0, -1, 0);
    run_frame(0, 1'b0, -1, 0);
`ifdef FFT_CTRL_PERF_EN
    chk("perf_count",  32'(frame_count),  2);
    chk("perf_cycles", 32'(frame_cycles), 16);
`endif

    // 2: staggered done; stage advances only after the slowest unit.
    set_offsets(4, 1, 9);
    run_frame(1, 1'b0, -1, 0);

    // 3: unit 5 never completes -> timeout; next frame clears the flag.
    set_offsets(3, 3, 3);
    hang = 5;
    run_frame(0, 1'b0, -1, 0);
    hang = -1;
    run_frame(0, 1'b0, -1, 0);

    // Completion on the final allowed WAIT cycle beats the timeout.
    set_offsets(3, 3, TIMEOUT_CYC);
    run_frame(0, 1'b0, -1, 0);

    // 4: downstream stalls 10 cycles, then a back-to-back frame.
    set_offsets(3, 3, 3);
    run_frame(10, 1'b0, -1, 0);
    run_frame(0, 1'b0, -1, 0);

    // 5: reset during stage-2 WAIT, then a normal frame.
    run_frame(0, 1'b0, 2, 2);
    run_frame(0, 1'b0, -1, 0);

    // Randomized frames with stray/repeated done pulses and held in_valid.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NUM_VU; i++) off[i] = int'($urandom_range(1, 8));
      hang = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_VU - 1)) : -1;
      run_frame(int'($urandom_range(0, 5)), 1'b1, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
